// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: shifts a preformatted UART frame out LSB first, one bit per baud tick,
// chaining frames back-to-back when the holding register has the next one ready.
module uart_tx_serializer #(
  parameter int FRAME_W = 12,
  parameter int MIN_LEN = 7
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               baud_tick,
  input  logic [FRAME_W-1:0] frame_i,
  input  logic               frame_valid_i,
  input  logic [3:0]         frame_len_i,
  output logic               enable_o,
  output logic               tx_o,
  output logic               busy_o,
  output logic               done_o
);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;
  logic [0:0]         state_q, state_d;
  logic               tx_q, tx_d, en_q, en_d, done_q, done_d;
  logic [FRAME_W-1:0] sh_q, sh_d;
  logic [3:0]         cnt_q, cnt_d, len_c;
  logic               last, load;
  always_comb begin
    len_c = frame_len_i < 4'(MIN_LEN) ? 4'(MIN_LEN)
          : frame_len_i > 4'(FRAME_W) ? 4'(FRAME_W) : frame_len_i;
    last  = baud_tick && state_q == SHIFT && cnt_q == 4'd0;
    // a new frame loads from idle or on the final tick of the current one
    load  = baud_tick && frame_valid_i && (state_q == IDLE || last);
  end
  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    en_d    = load;
    done_d  = last;
    if (load) begin
      state_d = SHIFT;
      tx_d    = frame_i[0];
      sh_d    = frame_i >> 1;
      cnt_d   = len_c - 4'd1;
    end else if (last) begin
      state_d = IDLE;
      tx_d    = 1'b1;
    end else if (baud_tick && state_q == SHIFT) begin
      tx_d    = sh_q[0];
      sh_d    = sh_q >> 1;
      cnt_d   = cnt_q - 4'd1;
    end
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      tx_q    <= 1'b1;
      sh_q    <= '0;
      cnt_q   <= '0;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      done_q  <= done_d;
    end
  end
  assign enable_o = en_q;
  assign done_o   = done_q;
  assign tx_o     = tx_q;
  assign busy_o   = state_q == SHIFT;
endmodule
